// File: rtl/otter_pkg.sv
// Shared OTTER types: redirect source codes, fetch FSM states, canonical nop.
// Latency: n/a (types only). Backpressure: n/a.
package otter_pkg;

  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pc_src_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/otter_fetch_seq_if.sv
// Fetch sequencer bus: redirect resolve inputs, imem req/ack, decode buffer, flush.
// Latency: n/a. Backpressure: imem via ack, decode via if_ready. Trap ports under OTTER_FETCH_TRAP_EN.
interface otter_fetch_seq_if;
  logic        resolve_valid;
  logic [2:0]  pc_source;
  logic [31:0] jalr_target;
  logic [31:0] branch_target;
  logic [31:0] jal_target;
`ifdef OTTER_FETCH_TRAP_EN
  logic [31:0] mtvec;
  logic [31:0] mepc;
`endif
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;

  modport master (
`ifdef OTTER_FETCH_TRAP_EN
    input  mtvec,
    input  mepc,
`endif
    input  resolve_valid,
    input  pc_source,
    input  jalr_target,
    input  branch_target,
    input  jal_target,
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output if_valid,
    output if_pc,
    output if_instr,
    input  if_ready,
    output flush
  );

  modport slave (
`ifdef OTTER_FETCH_TRAP_EN
    output mtvec,
    output mepc,
`endif
    output resolve_valid,
    output pc_source,
    output jalr_target,
    output branch_target,
    output jal_target,
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  if_valid,
    input  if_pc,
    input  if_instr,
    output if_ready,
    input  flush
  );
endinterface

// File: rtl/pc_target_mux.sv
// Redirect decode: picks and aligns the target for the resolved pc_source code.
// Latency: combinational. Backpressure: none. Trap codes 4/5 only with OTTER_FETCH_TRAP_EN.
module pc_target_mux
  import otter_pkg::*;
(
  input  logic        resolve_valid,
  input  logic [2:0]  pc_source,
  input  logic [31:0] jalr_target,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
`ifdef OTTER_FETCH_TRAP_EN
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
`endif
  output logic        redirect,
  output logic [31:0] target
);

  logic legal;

  always_comb begin
    legal  = 1'b0;
    target = jal_target;
    case (pc_source)
      PC_JALR: begin
        legal  = 1'b1;
        target = {jalr_target[31:1], 1'b0};
      end
      PC_BRANCH: begin
        legal  = 1'b1;
        target = branch_target;
      end
      PC_JAL: begin
        legal  = 1'b1;
        target = jal_target;
      end
`ifdef OTTER_FETCH_TRAP_EN
      PC_MTVEC: begin
        legal  = 1'b1;
        target = {mtvec[31:2], 2'b00};
      end
      PC_MEPC: begin
        legal  = 1'b1;
        target = {mepc[31:2], 2'b00};
      end
`endif
      // PC_PLUS4 and unused codes fall through as sequential flow
      default: begin
        legal  = 1'b0;
        target = jal_target;
      end
    endcase
    redirect = resolve_valid & legal;
  end

endmodule

// File: rtl/otter_fetch_seq.sv
// OTTER fetch sequencer: owns PC, one outstanding imem request, one-entry decode buffer.
// Latency: req->if_valid 1 cycle on zero-wait ack; flush 1 cycle after redirect. Backpressure: holds buffer while if_ready=0.
// Optional trap redirects (mtvec/mepc) under OTTER_FETCH_TRAP_EN.
module otter_fetch_seq
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input logic              CLK,
  input logic              RST_N,
  otter_fetch_seq_if.master bus
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  req_addr, req_addr_n;
  logic         kill, kill_n;
  logic         if_valid_q, if_valid_n;
  logic [31:0]  if_pc_q, if_pc_n;
  logic [31:0]  if_instr_q, if_instr_n;
  logic         flush_q;
  logic         redirect;
  logic [31:0]  target;

  pc_target_mux u_mux (
    .resolve_valid (bus.resolve_valid),
    .pc_source     (bus.pc_source),
    .jalr_target   (bus.jalr_target),
    .branch_target (bus.branch_target),
    .jal_target    (bus.jal_target),
`ifdef OTTER_FETCH_TRAP_EN
    .mtvec         (bus.mtvec),
    .mepc          (bus.mepc),
`endif
    .redirect      (redirect),
    .target        (target)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      pc         <= RESET_VEC;
      req_addr   <= RESET_VEC;
      kill       <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP_INSTR;
      flush_q    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_addr   <= req_addr_n;
      kill       <= kill_n;
      if_valid_q <= if_valid_n;
      if_pc_q    <= if_pc_n;
      if_instr_q <= if_instr_n;
      flush_q    <= redirect;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    kill_n     = kill;
    if_valid_n = if_valid_q;
    if_pc_n    = if_pc_q;
    if_instr_n = if_instr_q;
    case (state)
      IDLE: begin
        state_n    = REQ;
        pc_n       = redirect ? target : pc;
        req_addr_n = redirect ? target : pc;
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (redirect) begin
            kill_n     = 1'b0;
            pc_n       = target;
            req_addr_n = target;
          end else if (kill) begin
            // stale response for a redirected-away address: reissue at the new PC
            kill_n     = 1'b0;
            req_addr_n = pc;
          end else begin
            if_valid_n = 1'b1;
            if_pc_n    = req_addr;
            if_instr_n = bus.imem_rdata;
            pc_n       = seq_pc(req_addr);
            state_n    = HOLD;
          end
        end else if (redirect) begin
          // address must stay stable until ack, so only mark the response dead
          kill_n = 1'b1;
          pc_n   = target;
        end
      end
      HOLD: begin
        if (redirect) begin
          if_valid_n = 1'b0;
          pc_n       = target;
          req_addr_n = target;
          state_n    = REQ;
        end else if (bus.if_ready) begin
          if_valid_n = 1'b0;
          req_addr_n = pc;
          state_n    = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.imem_req  = (state == REQ);
  assign bus.imem_addr = req_addr;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.flush     = flush_q;

endmodule

// File: doc/otter_fetch_seq.md
# otter_fetch_seq

Fetch sequencer for the OTTER core: owns the program counter, issues instruction-memory requests over a req/ack handshake, buffers one fetched instruction for decode, and applies redirects selected by the branch-condition generator's `pcSource` code. It sits between instruction memory and decode and is the only writer of the PC.

## Interface
- `RESET_VEC`, default 32'h0000_0000: PC value loaded on reset.
- `CLK` in 1: core clock; all state on rising edge.
- `RST_N` in 1: reset, asynchronous assert, active-low.
- `resolve_valid` in 1: the EX-stage instruction is valid and `pc_source` is meaningful.
- `pc_source` in 3: 0 = pc+4, 1 = jalr, 2 = branch, 3 = jal; 4/5 are trap codes (see Configuration).
- `jalr_target`, `branch_target`, `jal_target` in 32 each: redirect targets, one per source.
- `imem_req` out 1, `imem_addr` out 32: fetch request and its address.
- `imem_ack` in 1, `imem_rdata` in 32: request completion and data, valid in the same cycle.
- `if_valid` out 1, `if_pc` out 32, `if_instr` out 32: buffered instruction to decode.
- `if_ready` in 1: decode accepts the buffer this cycle.
- `flush` out 1: one-cycle pulse; decode and EX drop their younger instructions.

## Operation
- A redirect is accepted at an edge where `resolve_valid`=1 and `pc_source` is nonzero and legal. Target is chosen by code. A jalr target has bit 0 forced to 0.
- State `IDLE` is entered from reset only. It lasts one cycle and then moves to `REQ`.
- State `REQ`:
  - `imem_req`=1 and `imem_addr`=`req_addr`. `req_addr` is latched from `pc` on entry and is held stable until ack.
  - On ack with no kill pending and no redirect: `if_instr`<=`imem_rdata`, `if_pc`<=`req_addr`, `pc`<=`req_addr`+4, go to `HOLD`.
  - On ack with kill pending: discard the data, clear kill, stay in `REQ`, and reissue with the current `pc`.
  - On ack in the same cycle as a redirect: discard the data, `pc`<=target, stay in `REQ`.
  - On a redirect with no ack: set kill, `pc`<=target. The outstanding request is still completed and then discarded.
- State `HOLD`:
  - `if_valid`=1 and `imem_req`=0.
  - If `if_ready`=1: the buffer is consumed, go to `REQ`.
  - On a redirect: invalidate the buffer, `pc`<=target, go to `REQ`. A redirect wins over `if_ready`, and the consume is ignored.
- `flush` is registered. It is 1 in the cycle after any accepted redirect and 0 otherwise.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

## Timing
- Reset values: `pc`=`req_addr`=`RESET_VEC`, `imem_req`=0, `imem_addr`=`RESET_VEC`, `if_valid`=0, `if_pc`=0, `if_instr`=32'h0000_0013 (nop), `flush`=0, kill=0, state `IDLE`.
- The first `imem_req` appears in the second cycle after `RST_N` deasserts.
- Zero-wait ack gives `if_valid` the cycle after the request. Throughput is one instruction per 2 cycles minimum (non-overlapped).
- Redirect to target request: target on `imem_addr` the cycle after acceptance when no request is outstanding; otherwise the cycle after the outstanding ack.
- Asserting `RST_N` low mid-request forces reset values immediately. A late `imem_ack` after reset is ignored in `IDLE`.

## Configuration
- `OTTER_FETCH_TRAP_EN` defined:
  - Adds inputs `mtvec` in 32 and `mepc` in 32.
  - `pc_source` 4 redirects to `mtvec`, and 5 (mret) redirects to `mepc`. Both force bits [1:0] to 0.
  - Both assert `flush` exactly like the other redirects.
- Undefined: the ports are absent, and codes 4–7 are treated as 0 (no redirect, no flush).

## Structure
- Shared package `otter_pkg` holds:
  - `pc_src_t` enum (PC_PLUS4, PC_JALR, PC_BRANCH, PC_JAL, PC_MTVEC, PC_MEPC).
  - `fetch_state_t` enum (IDLE, REQ, HOLD).
  - `NOP_INSTR` = 32'h0000_0013.
- One sub-module, `pc_target_mux`: combinational target select plus alignment. It produces `redirect` and `target` from `pc_source`, `resolve_valid` and the target inputs.

## Test plan
- Reset release with `RESET_VEC`=32'h100 and zero-wait ack returning 32'h00A00093, `if_ready`=1 → requests at 0x100, 0x104, 0x108 on alternating cycles; `if_pc` follows the same addresses; `flush` stays 0.
- In `HOLD`, apply `resolve_valid`=1, `pc_source`=2, `branch_target`=32'h200, with `if_ready`=1 in the same cycle → buffer dropped, `flush` pulses one cycle, next `imem_addr`=0x200.
- Ack delayed 3 cycles and a jal redirect to 0x300 in the first wait cycle → `imem_addr` holds its old address until the ack; that data never reaches `if_valid`; next request is to 0x300.
- `pc_source`=1 with `jalr_target`=32'h0000_0401 → next fetch at 0x400.
- `if_ready`=0 for 5 cycles in `HOLD` → `if_valid`, `if_pc` and `if_instr` stay stable; no `imem_req`. PC at 32'hFFFF_FFFC wraps to next fetch at 0x0.
- With `OTTER_FETCH_TRAP_EN`: `pc_source`=4, `mtvec`=32'h8000_0003 → fetch at 0x8000_0000 with a `flush` pulse. Without the macro, `pc_source`=4 gives no flush and sequential fetch.
